// File: rtl/latch_bank_wr_ctrl_if.sv
// Writeback request bundle for the latch-bank write controller: two
// valid/ready requesters (A = ALU, B = load/memory) with address and data.
interface latch_bank_wr_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// Write-port controller for a D-latch register bank: round-robin arbitration of two
// writeback requesters, then a setup -> enable pulse -> hold sequence per write.
module latch_bank_wr_ctrl #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int PULSE_CYC = 1,
  parameter int ZERO_PROT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  latch_bank_wr_ctrl_if.slave  wr_if,
  output logic [DW-1:0]        lat_d_o,
  output logic [NREG-1:0]      lat_en_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic [NREG-1:0] lat_en_q, lat_en_d;
  logic [NREG-1:0] en_mask;
  logic            prio_q, prio_d;   // 0: A wins a conflict, 1: B wins
  logic            err_q, err_d;
  logic            idle, a_grant, b_grant;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_data;

  assign idle    = (state_q == S_IDLE);
  assign a_grant = idle & wr_if.a_valid & (~wr_if.b_valid | ~prio_q);
  assign b_grant = idle & wr_if.b_valid & (~wr_if.a_valid |  prio_q);
  assign wr_if.a_ready = a_grant;
  assign wr_if.b_ready = b_grant;

  assign acc_addr = b_grant ? wr_if.b_addr : wr_if.a_addr;
  assign acc_data = b_grant ? wr_if.b_data : wr_if.a_data;

  // Out-of-range addresses match no bit, so they never raise an enable.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_en
      if (ZERO_PROT != 0 && gi == 0) begin : g_prot
        assign en_mask[gi] = 1'b0;
      end else begin : g_dec
        assign en_mask[gi] = (addr_q == AW'(gi));
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    lat_en_d = lat_en_q;
    prio_d   = prio_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_grant || b_grant) begin
          addr_d  = acc_addr;
          lat_d_d = acc_data;
          prio_d  = a_grant;
          err_d   = ({1'b0, acc_addr} >= NREG_W);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d    = '0;
        lat_en_d = en_mask;
        state_d  = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          lat_en_d = '0;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        lat_en_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      prio_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      prio_q   <= prio_d;
      err_q    <= err_d;
    end
  end

  assign lat_d_o  = lat_d_q;
  assign lat_en_o = lat_en_q;
  assign busy_o   = ~idle;
  assign err_o    = err_q;

endmodule
